// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: data memory, PCSrc, MEM/WB latch, post-reset clear sequencer
// Optional misaligned-access checker enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctl,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  input  logic [4:0]  five_bit_muxout,
  input  logic [31:0] EX_MEM_NPC,
  output logic        PCSrc,
  output logic        MEM_WB_regwrite,
  output logic        MEM_WB_memtoreg,
  output logic [31:0] MEM_WB_read_data,
  output logic [31:0] MEM_WB_alu_result,
  output logic [4:0]  MEM_WB_rd,
  output logic        mem_ready,
  output logic        misalign
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]          mem_q [DEPTH];

  logic                 regwrite_q, memtoreg_q, misalign_q;
  logic [31:0]          read_data_q, read_data_d;
  logic [31:0]          alu_result_q;
  logic [4:0]           rd_q;

  logic                 run;
  logic                 acc_misalign;
  logic [ADDR_BITS-1:0] word_addr;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [31:0]          mem_wdata;
  logic                 unused_npc;

  // The branch target is consumed by fetch directly; this stage never touches it.
  assign unused_npc = ^EX_MEM_NPC;

  assign run       = (state_q == ST_RUN);
  assign word_addr = alu_result[ADDR_BITS+1:2];
  assign PCSrc     = branch & zero;

`ifdef MEM_ALIGN_CHECK_EN
  assign acc_misalign = run & (memread | memwrite) & (alu_result[1:0] != 2'b00);
`else
  assign acc_misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = ST_RUN;
    end
  end

  // Clear pass owns the write port; a reset edge never writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = word_addr;
    mem_wdata = rdata2;
    if (rst_n) begin
      if (!run) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = 32'h0;
      end else if (memwrite && !acc_misalign) begin
        mem_we = 1'b1;
      end
    end
  end

  // Write-first: a same-cycle store is what the load observes.
  always_comb begin
    read_data_d = 32'h0;
    if (run && memread && !acc_misalign) begin
      if (memwrite) read_data_d = rdata2;
      else          read_data_d = mem_q[word_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      rd_q         <= 5'd0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      regwrite_q   <= wb_ctl[1] & run;
      memtoreg_q   <= wb_ctl[0];
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result;
      rd_q         <= five_bit_muxout;
      misalign_q   <= acc_misalign;
    end
  end

  assign MEM_WB_regwrite   = regwrite_q;
  assign MEM_WB_memtoreg   = memtoreg_q;
  assign MEM_WB_read_data  = read_data_q;
  assign MEM_WB_alu_result = alu_result_q;
  assign MEM_WB_rd         = rd_q;
  assign mem_ready         = run;
  assign misalign          = misalign_q;

endmodule
